// File: rtl/fsm_tx_burst.sv
// rtl/fsm_tx_burst.sv - FIFO-to-UART burst transmit sequencer with limit, abort and byte count
// Optional handshake watchdog is built when TX_TIMEOUT_EN is defined.
module fsm_tx_burst #(
  parameter int FIFO_RD_LAT = 1,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enviar_cmd,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             abort,
  input  logic             fifo_tx_empty,
  input  logic             uart_tx_rdy,
  output logic             fifo_tx_rd,
  output logic             uart_tx_start,
  output logic             enviar_bit_clear,
  output logic             busy,
  output logic [CNT_W-1:0] bytes_sent,
  output logic             timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK_FIFO, S_READ_FIFO, S_WAIT_DATA,
    S_SEND_UART, S_WAIT_ACK, S_WAIT_RDY, S_DONE
  } state_t;

  // WAIT_DATA covers FIFO_RD_LAT-1 cycles, so it exits when the counter hits FIFO_RD_LAT-2
  localparam logic [3:0] LAT_LAST = 4'(FIFO_RD_LAT > 1 ? FIFO_RD_LAT - 2 : 0);

  state_t           state, next_state;
  logic [CNT_W-1:0] limit;
  logic [3:0]       lat_cnt;
  logic             timeout_hit;
  logic             cmd_accept;

  assign cmd_accept = (state == S_IDLE) && enviar_cmd;

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:       if (enviar_cmd) next_state = S_CHECK_FIFO;
      S_CHECK_FIFO: begin
        if (abort || fifo_tx_empty || ((limit != '0) && (bytes_sent == limit)))
          next_state = S_DONE;
        else if (uart_tx_rdy)
          next_state = S_READ_FIFO;
      end
      S_READ_FIFO:  next_state = (FIFO_RD_LAT == 1) ? S_SEND_UART : S_WAIT_DATA;
      S_WAIT_DATA:  if (lat_cnt == LAT_LAST) next_state = S_SEND_UART;
      S_SEND_UART:  next_state = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (!uart_tx_rdy)     next_state = S_WAIT_RDY;
        else if (timeout_hit) next_state = S_DONE;
      end
      S_WAIT_RDY: begin
        if (uart_tx_rdy)      next_state = S_CHECK_FIFO;
        else if (timeout_hit) next_state = S_DONE;
      end
      S_DONE:       next_state = S_IDLE;
      default:      next_state = S_IDLE;
    endcase
  end

  // Strobes are flopped from next_state so they are glitch-free and line up with the state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      fifo_tx_rd       <= 1'b0;
      uart_tx_start    <= 1'b0;
      enviar_bit_clear <= 1'b0;
      busy             <= 1'b0;
    end else begin
      state            <= next_state;
      fifo_tx_rd       <= (next_state == S_READ_FIFO);
      uart_tx_start    <= (next_state == S_SEND_UART);
      enviar_bit_clear <= (next_state == S_DONE);
      busy             <= (next_state != S_IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      limit      <= '0;
      bytes_sent <= '0;
      lat_cnt    <= '0;
    end else begin
      if (cmd_accept) begin
        limit      <= burst_len;
        bytes_sent <= '0;
      end else if ((state == S_SEND_UART) && (bytes_sent != {CNT_W{1'b1}})) begin
        bytes_sent <= bytes_sent + CNT_W'(1);
      end
      lat_cnt <= (state == S_WAIT_DATA) ? lat_cnt + 4'd1 : 4'd0;
    end
  end

`ifdef TX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt;
  logic            wait_state;
  logic            wait_entry;

  assign wait_state  = (state == S_WAIT_ACK) || (state == S_WAIT_RDY);
  assign wait_entry  = ((next_state == S_WAIT_ACK) || (next_state == S_WAIT_RDY)) && (next_state != state);
  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (wait_entry)      to_cnt <= '0;
      else if (wait_state) to_cnt <= to_cnt + TO_W'(1);
      if (cmd_accept)
        timeout_err <= 1'b0;
      else if (wait_state && (next_state == S_DONE))
        timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_tx_burst.sv
// tb/tb_fsm_tx_burst.sv - randomized self-checking bench for fsm_tx_burst
// Timeout scenario follows TX_TIMEOUT_EN; FIFO and UART are behavioural models.
module tb_fsm_tx_burst;
  localparam int LAT = 3;
  localparam int CW  = 4;
  localparam int TO  = 16;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enviar_cmd = 1'b0;
  logic [CW-1:0] burst_len = '0;
  logic          abort = 1'b0;
  logic          fifo_tx_empty;
  logic          uart_tx_rdy = 1'b1;
  logic          fifo_tx_rd, uart_tx_start, enviar_bit_clear, busy, timeout_err;
  logic [CW-1:0] bytes_sent;

  int cyc = 0, cmd_cyc = 0;
  int fifo_loaded = 0, rd_total = 0, start_total = 0, clr_total = 0;
  int lat_bad = 0, strobe_bad = 0, last_clr_cyc = 0, first_to_cyc = 0, last_rd_cyc = 0;
  int rd_q[$], start_q[$];
  int ack_dly = 2, busy_dly = 10;
  bit uart_stuck = 1'b0;
  int total = 0, bad = 0;

  assign fifo_tx_empty = (fifo_loaded == rd_total);

  fsm_tx_burst #(.FIFO_RD_LAT(LAT), .CNT_W(CW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .enviar_cmd(enviar_cmd), .burst_len(burst_len), .abort(abort),
    .fifo_tx_empty(fifo_tx_empty), .uart_tx_rdy(uart_tx_rdy), .fifo_tx_rd(fifo_tx_rd),
    .uart_tx_start(uart_tx_start), .enviar_bit_clear(enviar_bit_clear), .busy(busy),
    .bytes_sent(bytes_sent), .timeout_err(timeout_err)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // Event monitor: counts strobes, records their cycles, flags multi-cycle strobes and bad latency
  initial begin
    bit p_rd, p_st, p_clr, p_to;
    p_rd = 0; p_st = 0; p_clr = 0; p_to = 0;
    forever begin
      @(negedge clk);
      if (fifo_tx_rd) begin
        if (p_rd) strobe_bad++;
        rd_total++; rd_q.push_back(cyc); last_rd_cyc = cyc;
      end
      if (uart_tx_start) begin
        if (p_st) strobe_bad++;
        if (cyc - last_rd_cyc != LAT) lat_bad++;
        start_total++; start_q.push_back(cyc);
      end
      if (enviar_bit_clear) begin
        if (p_clr) strobe_bad++;
        clr_total++; last_clr_cyc = cyc;
      end
      if (timeout_err && !p_to) first_to_cyc = cyc;
      p_rd = fifo_tx_rd; p_st = uart_tx_start; p_clr = enviar_bit_clear; p_to = timeout_err;
    end
  end

  // UART model: accepts a started byte after ack_dly cycles, becomes ready busy_dly cycles later
  initial forever begin
    @(negedge clk);
    if (uart_tx_start && !uart_stuck) begin
      repeat (ack_dly) @(negedge clk);
      uart_tx_rdy = 1'b0;
      repeat (busy_dly) @(negedge clk);
      uart_tx_rdy = 1'b1;
    end
  end

  task automatic launch(input int level, input int bl, input bit ab);
    @(negedge clk);
    fifo_loaded = rd_total + level;
    burst_len = CW'(bl); abort = ab; enviar_cmd = 1'b1; cmd_cyc = cyc + 1;
    @(negedge clk);
    enviar_cmd = 1'b0; burst_len = CW'($urandom);
  endtask

  task automatic wait_done(output bit ok);
    int c0 = clr_total;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (clr_total != c0) begin ok = 1'b1; break; end
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1; #1;
    total++; if ({fifo_tx_rd, uart_tx_start, enviar_bit_clear, busy, timeout_err, bytes_sent} !== '0) begin bad++; $display("FAIL reset_outputs: got busy=%0b bytes=%0d want all zero", busy, bytes_sent); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle: busy=%0b want 0", busy); end
  endtask

  task automatic test_drain();
    int rd0 = rd_total, st0 = start_total, c0 = clr_total, lb0 = lat_bad; bit ok;
    ack_dly = 2; busy_dly = 10;
    launch(3, 0, 0);
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL drain_done: no clear pulse within budget"); end
    total++; if (rd_total - rd0 != 3 || start_total - st0 != 3) begin bad++; $display("FAIL drain_count: rd=%0d start=%0d want 3/3", rd_total - rd0, start_total - st0); end
    total++; if (rd_q.size() <= rd0 || rd_q[rd0] - cmd_cyc != 1) begin bad++; $display("FAIL drain_first_rd: rd cycle offset wrong, want 1 after cmd edge"); end
    total++; if (lat_bad != lb0) begin bad++; $display("FAIL drain_latency: %0d starts not %0d cycles after rd", lat_bad - lb0, LAT); end
    total++; if (bytes_sent !== CW'(3) || clr_total - c0 != 1 || busy !== 1'b0) begin bad++; $display("FAIL drain_end: bytes=%0d clr=%0d busy=%0b want 3/1/0", bytes_sent, clr_total - c0, busy); end
  endtask

  task automatic test_limit();
    int rd0 = rd_total; bit ok;
    launch(5, 2, 0);
    wait_done(ok);
    total++; if (!ok || rd_total - rd0 != 2 || bytes_sent !== CW'(2)) begin bad++; $display("FAIL limit: ok=%0b rd=%0d bytes=%0d want 1/2/2", ok, rd_total - rd0, bytes_sent); end
    total++; if (fifo_tx_empty !== 1'b0) begin bad++; $display("FAIL limit_fifo: empty=%0b want 0", fifo_tx_empty); end
  endtask

  task automatic test_empty();
    int rd0 = rd_total, st0 = start_total; bit ok;
    launch(0, 0, 0);
    wait_done(ok);
    total++; if (!ok || rd_total != rd0 || start_total != st0 || bytes_sent !== '0) begin bad++; $display("FAIL empty: ok=%0b rd=%0d start=%0d bytes=%0d want 1/0/0/0", ok, rd_total - rd0, start_total - st0, bytes_sent); end
    total++; if (last_clr_cyc - cmd_cyc != 1) begin bad++; $display("FAIL empty_clr_time: offset=%0d want 1", last_clr_cyc - cmd_cyc); end
  endtask

  task automatic test_abort();
    int rd0 = rd_total, st0 = start_total; bit ok, seen;
    ack_dly = 1; busy_dly = 8; seen = 0;
    launch(5, 0, 0);
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk); #1;
      if (start_total - st0 == 2 && uart_tx_rdy == 1'b0) begin abort = 1'b1; seen = 1; end
    end
    total++; if (!seen) begin bad++; $display("FAIL abort_reach: second byte wait_rdy not reached"); end
    wait_done(ok);
    abort = 1'b0;
    total++; if (!ok || rd_total - rd0 != 2 || start_total - st0 != 2 || bytes_sent !== CW'(2)) begin bad++; $display("FAIL abort: ok=%0b rd=%0d start=%0d bytes=%0d want 1/2/2/2", ok, rd_total - rd0, start_total - st0, bytes_sent); end
    total++; if (start_q.size() < st0 + 2 || start_q[st0 + 1] - rd_q[rd0 + 1] != LAT) begin bad++; $display("FAIL abort_latency: second start not %0d cycles after rd", LAT); end
    total++; if (fifo_loaded - rd_total != 3) begin bad++; $display("FAIL abort_fifo: left=%0d want 3", fifo_loaded - rd_total); end
  endtask

  task automatic test_abort_with_cmd();
    int rd0 = rd_total, c0 = clr_total; bit ok;
    @(negedge clk); abort = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (busy !== 1'b0 || clr_total != c0) begin bad++; $display("FAIL abort_idle: busy=%0b clr=%0d want 0/0", busy, clr_total - c0); end
    launch(4, 0, 1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_cmd_accept: busy=%0b want 1", busy); end
    wait_done(ok);
    abort = 1'b0;
    total++; if (!ok || rd_total != rd0 || bytes_sent !== '0) begin bad++; $display("FAIL abort_cmd: ok=%0b rd=%0d bytes=%0d want 1/0/0", ok, rd_total - rd0, bytes_sent); end
  endtask

  task automatic test_timeout();
    int st0 = start_total; bit ok;
    uart_stuck = 1'b1;
    launch(3, 0, 0);
`ifdef TX_TIMEOUT_EN
    wait_done(ok);
    total++; if (!ok || timeout_err !== 1'b1 || busy !== 1'b0 || bytes_sent !== CW'(1)) begin bad++; $display("FAIL timeout: ok=%0b err=%0b busy=%0b bytes=%0d want 1/1/0/1", ok, timeout_err, busy, bytes_sent); end
    total++; if (start_q.size() <= st0 || first_to_cyc - start_q[st0] - 1 != TO || last_clr_cyc != first_to_cyc) begin bad++; $display("FAIL timeout_time: err %0d cycles after wait_ack want %0d", first_to_cyc - start_q[st0] - 1, TO); end
    uart_stuck = 1'b0;
    launch(1, 0, 0);
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL timeout_clear: err=%0b want 0", timeout_err); end
    wait_done(ok);
`else
    ok = 1'b1;
    repeat (40) @(negedge clk);
    total++; if (!ok || timeout_err !== 1'b0 || busy !== 1'b1 || start_total - st0 != 1) begin bad++; $display("FAIL no_timeout: err=%0b busy=%0b start=%0d want 0/1/1", timeout_err, busy, start_total - st0); end
    uart_stuck = 1'b0;
    do_reset();
`endif
  endtask

  task automatic test_reset_mid();
    int rd0 = rd_total, st0; bit seen = 0;
    ack_dly = 1; busy_dly = 3;
    launch(4, 0, 0);
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (rd_total - rd0 == 2) seen = 1;
    end
    st0 = start_total;
    @(negedge clk); #2;
    total++; if (!seen || bytes_sent !== CW'(1)) begin bad++; $display("FAIL reset_mid_pre: seen=%0b bytes=%0d want 1/1", seen, bytes_sent); end
    rst = 1'b1; #1;
    total++; if ({fifo_tx_rd, uart_tx_start, enviar_bit_clear, busy, timeout_err, bytes_sent} !== '0) begin bad++; $display("FAIL reset_mid_async: busy=%0b bytes=%0d want all zero", busy, bytes_sent); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    total++; if (start_total != st0 || busy !== 1'b0 || bytes_sent !== '0) begin bad++; $display("FAIL reset_mid_after: start=%0d busy=%0b bytes=%0d want 0/0/0", start_total - st0, busy, bytes_sent); end
  endtask

  task automatic test_saturate();
    int rd0 = rd_total; bit ok;
    ack_dly = 1; busy_dly = 2;
    launch(SAT + 3, 0, 0);
    wait_done(ok);
    total++; if (!ok || rd_total - rd0 != SAT + 3 || bytes_sent !== CW'(SAT)) begin bad++; $display("FAIL saturate: ok=%0b rd=%0d bytes=%0d want 1/%0d/%0d", ok, rd_total - rd0, bytes_sent, SAT + 3, SAT); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      int level = int'($urandom_range(0, 6));
      int bl    = int'($urandom_range(0, 7));
      int pops  = (bl == 0 || level < bl) ? level : bl;
      int rd0 = rd_total, st0 = start_total, c0 = clr_total, lb0 = lat_bad;
      bit ok;
      ack_dly = int'($urandom_range(1, 3)); busy_dly = int'($urandom_range(1, 12));
      launch(level, bl, 0);
      wait_done(ok);
      total++; if (!ok || rd_total - rd0 != pops || start_total - st0 != pops || clr_total - c0 != 1) begin bad++; $display("FAIL random_%0d: lvl=%0d bl=%0d rd=%0d start=%0d clr=%0d want %0d/%0d/1", n, level, bl, rd_total - rd0, start_total - st0, clr_total - c0, pops, pops); end
      total++; if (bytes_sent !== CW'(pops) || busy !== 1'b0 || lat_bad != lb0) begin bad++; $display("FAIL random_end_%0d: bytes=%0d busy=%0b latbad=%0d want %0d/0/0", n, bytes_sent, busy, lat_bad - lb0, pops); end
    end
    total++; if (strobe_bad != 0) begin bad++; $display("FAIL strobe_width: %0d strobes longer than one cycle want 0", strobe_bad); end
  endtask

  initial begin
    test_reset();
    test_drain();
    test_limit();
    test_empty();
    test_abort();
    test_abort_with_cmd();
    test_timeout();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
